// File: rtl/i2c_slave_regfile.sv
// I2C target with an auto-incrementing byte register file and local write port.
// Optional input glitch filter: define I2C_SLAVE_GLITCH_FILTER_EN.
module i2c_slave_regfile #(
  parameter logic [6:0] I2C_ADDR  = 7'h4B,
  parameter int         REG_COUNT = 16
) (
  input  logic       i_clk,
  input  logic       reset_n,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe,
  input  logic       loc_we,
  input  logic [7:0] loc_addr,
  input  logic [7:0] loc_wdata,
  output logic       rx_valid,
  output logic [7:0] rx_addr,
  output logic [7:0] rx_data,
  output logic       busy
);

  localparam int AW = (REG_COUNT > 1) ? $clog2(REG_COUNT) : 1;
  localparam logic [8:0] RC = 9'(REG_COUNT);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK,
    WDATA, WDATA_ACK, RDATA, RDATA_ACK, WAIT
  } state_t;

  state_t     state, state_n;
  logic [3:0] cnt, cnt_n;
  logic [7:0] sh, sh_n;
  logic [7:0] ptr, ptr_n;
  logic       oe_n, busy_n;
  logic       wr_en;
  logic [7:0] byte_in, ptr_inc, rd_cur, rd_nxt;
  logic [7:0] regs [REG_COUNT];

  logic [1:0] scl_sy, sda_sy;
  logic       scl_c, sda_c, scl_p, sda_p;
  logic       scl_rise, scl_fall, start_det, stop_det;

  // Two-flop synchronizers; idle bus is high
  always_ff @(posedge i_clk or negedge reset_n) begin
    if (!reset_n) begin
      scl_sy <= 2'b11;
      sda_sy <= 2'b11;
    end else begin
      scl_sy <= {scl_sy[0], scl_i};
      sda_sy <= {sda_sy[0], sda_i};
    end
  end

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
  logic [1:0] scl_h, sda_h;
  logic       scl_f, sda_f;

  // Filtered level follows input only after 3 agreeing samples
  always_ff @(posedge i_clk or negedge reset_n) begin
    if (!reset_n) begin
      scl_h <= 2'b11;
      sda_h <= 2'b11;
      scl_f <= 1'b1;
      sda_f <= 1'b1;
    end else begin
      scl_h <= {scl_h[0], scl_sy[1]};
      sda_h <= {sda_h[0], sda_sy[1]};
      if (&{scl_h, scl_sy[1]})
        scl_f <= 1'b1;
      else if (~|{scl_h, scl_sy[1]})
        scl_f <= 1'b0;
      if (&{sda_h, sda_sy[1]})
        sda_f <= 1'b1;
      else if (~|{sda_h, sda_sy[1]})
        sda_f <= 1'b0;
    end
  end

  assign scl_c = scl_f;
  assign sda_c = sda_f;
`else
  assign scl_c = scl_sy[1];
  assign sda_c = sda_sy[1];
`endif

  // Previous line levels for edge detection
  always_ff @(posedge i_clk or negedge reset_n) begin
    if (!reset_n) begin
      scl_p <= 1'b1;
      sda_p <= 1'b1;
    end else begin
      scl_p <= scl_c;
      sda_p <= sda_c;
    end
  end

  assign scl_rise  = scl_c & ~scl_p;
  assign scl_fall  = ~scl_c & scl_p;
  assign start_det = scl_c & scl_p & sda_p & ~sda_c;
  assign stop_det  = scl_c & scl_p & ~sda_p & sda_c;
  assign byte_in   = {sh[6:0], sda_c};

  // Pointer increment: last or out-of-range pointer wraps to 0
  always_comb begin
    ptr_inc = ptr + 8'd1;
    if ({1'b0, ptr} + 9'd1 >= RC)
      ptr_inc = 8'd0;
  end

  // Read-side register lookup; unimplemented addresses read FF
  always_comb begin
    rd_cur = 8'hFF;
    rd_nxt = 8'hFF;
    if ({1'b0, ptr} < RC)
      rd_cur = regs[ptr[AW-1:0]];
    if ({1'b0, ptr_inc} < RC)
      rd_nxt = regs[ptr_inc[AW-1:0]];
  end

  // Protocol state and datapath registers
  always_ff @(posedge i_clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      cnt    <= 4'd0;
      sh     <= 8'd0;
      ptr    <= 8'd0;
      sda_oe <= 1'b0;
      busy   <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      sh     <= sh_n;
      ptr    <= ptr_n;
      sda_oe <= oe_n;
      busy   <= busy_n;
    end
  end

  // Next-state logic; START/STOP override every state
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    sh_n    = sh;
    ptr_n   = ptr;
    oe_n    = sda_oe;
    busy_n  = busy;
    wr_en   = 1'b0;
    if (start_det) begin
      state_n = ADDR;
      cnt_n   = 4'd0;
      oe_n    = 1'b0;
      busy_n  = 1'b0;
    end else if (stop_det) begin
      state_n = IDLE;
      oe_n    = 1'b0;
      busy_n  = 1'b0;
    end else begin
      unique case (state)
        IDLE: ;
        ADDR: if (scl_rise) begin
          sh_n  = byte_in;
          cnt_n = cnt + 4'd1;
          if (cnt == 4'd7) begin
            if (byte_in[7:1] == I2C_ADDR) begin
              state_n = ADDR_ACK;
              busy_n  = 1'b1;
            end else begin
              state_n = WAIT;
            end
          end
        end
        ADDR_ACK: if (scl_fall) begin
          cnt_n = 4'd0;
          if (!sda_oe) begin
            oe_n = 1'b1;
          end else if (sh[0]) begin
            sh_n    = rd_cur;
            oe_n    = ~rd_cur[7];
            state_n = RDATA;
          end else begin
            oe_n    = 1'b0;
            state_n = PTR;
          end
        end
        PTR: if (scl_rise) begin
          sh_n  = byte_in;
          cnt_n = cnt + 4'd1;
          if (cnt == 4'd7) begin
            ptr_n   = byte_in;
            state_n = PTR_ACK;
          end
        end
        PTR_ACK: if (scl_fall) begin
          cnt_n = 4'd0;
          if (!sda_oe) begin
            oe_n = 1'b1;
          end else begin
            oe_n    = 1'b0;
            state_n = WDATA;
          end
        end
        WDATA: if (scl_rise) begin
          sh_n  = byte_in;
          cnt_n = cnt + 4'd1;
          if (cnt == 4'd7) begin
            wr_en   = ({1'b0, ptr} < RC);
            state_n = WDATA_ACK;
          end
        end
        WDATA_ACK: if (scl_fall) begin
          cnt_n = 4'd0;
          if (!sda_oe) begin
            oe_n = 1'b1;
          end else begin
            oe_n    = 1'b0;
            ptr_n   = ptr_inc;
            state_n = WDATA;
          end
        end
        RDATA: begin
          if (scl_rise)
            cnt_n = cnt + 4'd1;
          if (scl_fall) begin
            if (cnt == 4'd8) begin
              oe_n    = 1'b0;
              state_n = RDATA_ACK;
            end else begin
              sh_n = {sh[6:0], 1'b0};
              oe_n = ~sh[6];
            end
          end
        end
        RDATA_ACK: begin
          if (scl_rise) begin
            if (!sda_c) begin
              ptr_n = ptr_inc;
              sh_n  = rd_nxt;
            end else begin
              state_n = WAIT;
            end
          end
          if (scl_fall) begin
            oe_n    = ~sh[7];
            cnt_n   = 4'd0;
            state_n = RDATA;
          end
        end
        WAIT: ;
        default: state_n = IDLE;
      endcase
    end
  end

  // Register file; I2C commit overrides a same-cycle local write
  always_ff @(posedge i_clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < REG_COUNT; i++)
        regs[i] <= 8'd0;
    end else begin
      if (loc_we && ({1'b0, loc_addr} < RC))
        regs[loc_addr[AW-1:0]] <= loc_wdata;
      if (wr_en)
        regs[ptr[AW-1:0]] <= byte_in;
    end
  end

  // Commit report towards the application
  always_ff @(posedge i_clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_valid <= 1'b0;
      rx_addr  <= 8'd0;
      rx_data  <= 8'd0;
    end else begin
      rx_valid <= wr_en;
      if (wr_en) begin
        rx_addr <= ptr;
        rx_data <= byte_in;
      end
    end
  end

endmodule

// File: tb/tb_i2c_slave_regfile.sv
// Bench for i2c_slave_regfile: bit-banged I2C master,
// register-file model, directed cases plus random traffic.
module tb_i2c_slave_regfile;

  logic       i_clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       scl_i, sda_i, sda_oe;
  logic       loc_we = 1'b0;
  logic [7:0] loc_addr = 8'd0;
  logic [7:0] loc_wdata = 8'd0;
  logic       rx_valid, busy;
  logic [7:0] rx_addr, rx_data;

  assign scl_i = scl_m;
  assign sda_i = sda_m & ~sda_oe;

  always #5 i_clk = ~i_clk;

  i2c_slave_regfile dut (
    .i_clk    (i_clk),
    .reset_n  (reset_n),
    .scl_i    (scl_i),
    .sda_i    (sda_i),
    .sda_oe   (sda_oe),
    .loc_we   (loc_we),
    .loc_addr (loc_addr),
    .loc_wdata(loc_wdata),
    .rx_valid (rx_valid),
    .rx_addr  (rx_addr),
    .rx_data  (rx_data),
    .busy     (busy)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Monitor: log commits and count cycles with SDA driven
  logic [15:0] rx_log [1024];
  int rx_n = 0;
  int oe_cyc = 0;
  always @(negedge i_clk) begin
    if (rx_valid && rx_n < 1024) begin
      rx_log[rx_n] = {rx_addr, rx_data};
      rx_n++;
    end
    if (sda_oe) oe_cyc++;
  end

  // Reference model of the register file
  logic [7:0] mem [16];
  logic [7:0] mptr;

  function automatic logic [7:0] minc(input logic [7:0] p);
    return (p < 8'd15) ? p + 8'd1 : 8'd0;
  endfunction

  function automatic logic [7:0] mrd(input logic [7:0] p);
    return (p < 8'd16) ? mem[p[3:0]] : 8'hFF;
  endfunction

  task automatic mreset;
    for (int i = 0; i < 16; i++) mem[i] = 8'd0;
    mptr = 8'd0;
  endtask

  task automatic q;
    repeat (10) @(negedge i_clk);
  endtask

  task automatic bit_c(input logic v, output logic s);
    sda_m = v;
    q;
    scl_m = 1'b1;
    q;
    s = sda_i;
    q;
    scl_m = 1'b0;
    repeat (2) @(negedge i_clk);
  endtask

  task automatic start_c;
    sda_m = 1'b1;
    q;
    scl_m = 1'b1;
    q;
    sda_m = 1'b0;
    q;
    scl_m = 1'b0;
    repeat (2) @(negedge i_clk);
  endtask

  task automatic stop_c;
    sda_m = 1'b0;
    q;
    scl_m = 1'b1;
    q;
    sda_m = 1'b1;
    q;
  endtask

  task automatic wbyte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) bit_c(b[i], s);
    bit_c(1'b1, s);
    ack = ~s;
  endtask

  task automatic rbyte(input logic nack, output logic [7:0] b);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      bit_c(1'b1, s);
      b[i] = s;
    end
    bit_c(nack, s);
  endtask

  task automatic lwr(input logic [7:0] a, input logic [7:0] d);
    @(negedge i_clk);
    loc_we = 1'b1;
    loc_addr = a;
    loc_wdata = d;
    @(negedge i_clk);
    loc_we = 1'b0;
    if (a < 8'd16) mem[a[3:0]] = d;
  endtask

  // Write: pointer then n bytes (d byte k at d[8k+:8])
  task automatic i2c_wr(input logic [7:0] p, input int n,
                        input logic [31:0] d, input string tag);
    logic a;
    logic [15:0] exp [4];
    int ne, base;
    ne = 0;
    base = rx_n;
    start_c;
    wbyte(8'h96, a);
    chk({tag, ".aack"}, a, 1);
    wbyte(p, a);
    chk({tag, ".pack"}, a, 1);
    mptr = p;
    for (int k = 0; k < n; k++) begin
      wbyte(d[8*k +: 8], a);
      chk({tag, ".dack"}, a, 1);
      if (mptr < 8'd16) begin
        mem[mptr[3:0]] = d[8*k +: 8];
        exp[ne] = {mptr, d[8*k +: 8]};
        ne++;
      end
      mptr = minc(mptr);
    end
    chk({tag, ".busy"}, busy, 1);
    stop_c;
    chk({tag, ".idle"}, busy, 0);
    chk({tag, ".nrx"}, rx_n - base, ne);
    for (int k = 0; k < ne; k++)
      chk({tag, ".rx"}, rx_log[base+k], exp[k]);
  endtask

  // Read: set pointer, repeated START, read n bytes, NACK last
  task automatic i2c_rd(input logic [7:0] p, input int n,
                        input string tag);
    logic a;
    logic [7:0] b;
    start_c;
    wbyte(8'h96, a);
    chk({tag, ".aack"}, a, 1);
    wbyte(p, a);
    chk({tag, ".pack"}, a, 1);
    mptr = p;
    start_c;
    wbyte(8'h97, a);
    chk({tag, ".rack"}, a, 1);
    for (int k = 0; k < n; k++) begin
      rbyte(k == n - 1, b);
      chk({tag, ".data"}, b, mrd(mptr));
      if (k < n - 1) mptr = minc(mptr);
    end
    chk({tag, ".rel"}, sda_oe, 0);
    stop_c;
    chk({tag, ".idle"}, busy, 0);
  endtask

  initial begin
    logic a, s;
    logic [7:0] p;
    int base, o0, n;
    mreset;
    repeat (5) @(negedge i_clk);
    reset_n = 1'b1;
    @(negedge i_clk);
    chk("rst.oe", sda_oe, 0);
    chk("rst.busy", busy, 0);
    chk("rst.rxv", rx_valid, 0);
    chk("rst.rxa", rx_addr, 0);
    chk("rst.rxd", rx_data, 0);
    q;

    i2c_wr(8'h02, 2, 32'h5AA5, "t1");
    i2c_rd(8'h02, 2, "t2");

    base = rx_n;
    o0 = oe_cyc;
    start_c;
    wbyte(8'hA0, a);
    chk("t3.nack", a, 0);
    chk("t3.busy", busy, 0);
    wbyte(8'h55, a);
    stop_c;
    chk("t3.oe", oe_cyc - o0, 0);
    chk("t3.nrx", rx_n - base, 0);
    i2c_rd(8'h03, 1, "t3b");

    i2c_wr(8'h0F, 2, 32'h2211, "t4");
    i2c_rd(8'h0F, 2, "t4r");

    i2c_rd(8'h20, 1, "t5r");
    i2c_wr(8'h20, 1, 32'h33, "t5w");
    i2c_rd(8'h00, 16, "t5all");

    start_c;
    wbyte(8'h96, a);
    wbyte(8'h07, a);
    start_c;
    wbyte(8'h97, a);
    for (int i = 0; i < 3; i++) bit_c(1'b1, s);
    sda_m = 1'b1;
    q;
    scl_m = 1'b1;
    q;
    chk("t6.drv", sda_oe, 1);
    reset_n = 1'b0;
    #1;
    chk("t6.oe", sda_oe, 0);
    chk("t6.busy", busy, 0);
    mreset;
    scl_m = 1'b1;
    sda_m = 1'b1;
    repeat (5) @(negedge i_clk);
    reset_n = 1'b1;
    q;
    i2c_rd(8'h02, 1, "t6r");
    i2c_wr(8'h02, 2, 32'h5AA5, "t6w");

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
    o0 = oe_cyc;
    sda_m = 1'b0;
    repeat (2) @(negedge i_clk);
    sda_m = 1'b1;
    q;
    scl_m = 1'b0;
    q;
    wbyte(8'h96, a);
    chk("glf.nack", a, 0);
    chk("glf.busy", busy, 0);
    stop_c;
    chk("glf.oe", oe_cyc - o0, 0);
`endif

    for (int it = 0; it < 20; it++) begin
      if ($urandom_range(0, 5) == 0)
        p = 8'($urandom_range(16, 40));
      else
        p = 8'($urandom_range(0, 15));
      n = $urandom_range(1, 3);
      case ($urandom_range(0, 2))
        0: lwr(8'($urandom_range(0, 23)), 8'($urandom));
        1: i2c_wr(p, n, $urandom, "rw");
        default: i2c_rd(p, n, "rr");
      endcase
    end
    i2c_rd(8'h00, 16, "fin");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
